// File: rtl/acq_controller_if.sv
// acq_controller_if: control, ADC capture and PSRAM write signals of the acquisition controller
interface acq_controller_if #(
    parameter int ADDR_WIDTH = 22
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] num_samples;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  adc_ready;
    logic [11:0]           adc_data;
    logic                  adc_OTR;
    logic                  adc_enable;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;
    logic                  wr_ack;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [ADDR_WIDTH-1:0] sample_count;
    modport master (
        output start, abort, num_samples, base_addr, adc_ready, adc_data, adc_OTR, wr_ack,
        input  adc_enable, wr_req, wr_addr, wr_data, busy, done, overflow, sample_count
    );
    modport slave (
        input  start, abort, num_samples, base_addr, adc_ready, adc_data, adc_OTR, wr_ack,
        output adc_enable, wr_req, wr_addr, wr_data, busy, done, overflow, sample_count
    );
endinterface

// File: rtl/acq_controller.sv
// acq_controller: buffers ADC samples in a small FIFO and streams them to consecutive PSRAM addresses
module acq_controller #(
    parameter int ADDR_WIDTH = 22,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk_PSRAM,
    input logic             rst,
    acq_controller_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ACQ, DRAIN, DONE} state_t;
    state_t                r_state, w_next;
    logic [15:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW:0]           r_count;
    logic [ADDR_WIDTH-1:0] r_n, r_addr, r_sample_count;
    logic                  r_overflow, r_zero_done;
    logic                  w_empty, w_full, w_start_ok, w_zero_start, w_push, w_drop, w_pop, w_last;
    always_comb begin
        w_empty      = r_count == '0;
        w_full       = r_count == (PW+1)'(FIFO_DEPTH);
        w_start_ok   = r_state == IDLE && bus.start && bus.num_samples != '0;
        w_zero_start = r_state == IDLE && bus.start && bus.num_samples == '0;
        w_push       = r_state == ACQ && bus.adc_ready && !w_full;
        w_drop       = r_state == ACQ && bus.adc_ready && w_full;
        w_pop        = bus.wr_ack && !w_empty;
        w_last       = w_push && r_sample_count + ADDR_WIDTH'(1) == r_n;
        w_next       = r_state;
        w_next       = r_state == IDLE  ? (w_start_ok ? ACQ : IDLE) :
                       r_state == ACQ   ? ((bus.abort || w_last) ? DRAIN : ACQ) :
                       r_state == DRAIN ? (w_empty ? DONE : DRAIN) : IDLE;
    end
    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_n            <= '0;
            r_addr         <= '0;
            r_sample_count <= '0;
            r_overflow     <= 1'b0;
            r_zero_done    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_zero_done <= w_zero_start;
            r_count     <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_push) begin
                r_wr_ptr       <= r_wr_ptr + PW'(1);
                r_sample_count <= r_sample_count + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_addr   <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_start_ok) begin
                r_n            <= bus.num_samples;
                r_addr         <= bus.base_addr;
                r_sample_count <= '0;
                r_overflow     <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk_PSRAM)
        if (w_push)
            r_mem[r_wr_ptr] <= {3'b000, bus.adc_OTR, bus.adc_data};
    // The head is masked when empty so wr_data reads zero after reset and between runs
    assign bus.wr_data      = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign bus.wr_req       = !w_empty;
    assign bus.wr_addr      = r_addr;
    assign bus.adc_enable   = r_state == ACQ;
    assign bus.busy         = r_state != IDLE;
    assign bus.done         = r_state == DONE || r_zero_done;
    assign bus.overflow     = r_overflow;
    assign bus.sample_count = r_sample_count;
endmodule
